// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter and access sequencer for a single-port SRAM macro.
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN (alternating tie winner instead of fixed priority to requester 0).
module sram_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [1:0]          REQ,
    input  logic [1:0]          WE,
    input  logic [2*ADDR_W-1:0] ADDR,
    input  logic [2*STRB_W-1:0] WSTRB,
    input  logic [2*DATA_W-1:0] WDATA,
    output logic [1:0]          GNT,
    output logic [1:0]          RSP_VALID,
    input  logic [1:0]          RSP_READY,
    output logic [DATA_W-1:0]   RDATA,
    output logic                CS,
    output logic                OE,
    output logic [STRB_W-1:0]   WEB,
    output logic [ADDR_W-1:0]   A,
    output logic [DATA_W-1:0]   DI,
    input  logic [DATA_W-1:0]   DO
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_READ   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                grant_s;
    logic                win_s;
    logic                win_we_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [STRB_W-1:0]   win_wstrb_s;
    logic [DATA_W-1:0]   win_wdata_s;
    logic                rsp_done_s;
    logic                id_r;
    logic                we_r;
    logic                cs_r;
    logic                oe_r;
    logic [STRB_W-1:0]   web_r;
    logic [ADDR_W-1:0]   a_r;
    logic [DATA_W-1:0]   di_r;
    logic [1:0]          rsp_valid_r;
    logic [DATA_W-1:0]   rdata_r;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic                last_grant_r;
`endif

    // Arbitration: GNT is a Mealy pulse of IDLE so the SRAM access lands in the very next cycle
    always_comb begin
        grant_s = 1'b0;
        win_s   = 1'b0;
        if ((state_r == ST_IDLE) && (REQ != 2'b00)) begin
            grant_s = 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            if (REQ == 2'b11) begin
                win_s = ~last_grant_r;
            end else begin
                win_s = REQ[1];
            end
`else
            win_s = ~REQ[0];
`endif
        end else begin
            grant_s = 1'b0;
            win_s   = 1'b0;
        end
    end

    // Select the winning requester's operands
    always_comb begin
        win_we_s    = 1'b0;
        win_addr_s  = {ADDR_W{1'b0}};
        win_wstrb_s = {STRB_W{1'b0}};
        win_wdata_s = {DATA_W{1'b0}};
        if (win_s) begin
            win_we_s    = WE[1];
            win_addr_s  = ADDR[2*ADDR_W-1:ADDR_W];
            win_wstrb_s = WSTRB[2*STRB_W-1:STRB_W];
            win_wdata_s = WDATA[2*DATA_W-1:DATA_W];
        end else begin
            win_we_s    = WE[0];
            win_addr_s  = ADDR[ADDR_W-1:0];
            win_wstrb_s = WSTRB[STRB_W-1:0];
            win_wdata_s = WDATA[DATA_W-1:0];
        end
    end

    assign GNT        = {grant_s & win_s, grant_s & ~win_s};
    assign rsp_done_s = (state_r == ST_RESP) && RSP_READY[id_r];

    // Next-state logic for the access sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (we_r) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_READ: state_s = ST_RESP;
            ST_RESP: begin
                if (rsp_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and latched request attributes
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_r <= ST_IDLE;
            id_r    <= 1'b0;
            we_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            if (grant_s) begin
                id_r <= win_s;
                we_r <= win_we_s;
            end
        end
    end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Remember the last winner; reset value lets requester 0 take the first tie
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            last_grant_r <= 1'b1;
        end else if (grant_s) begin
            last_grant_r <= win_s;
        end
    end
`endif

    // SRAM pins, registered from the next state so they line up with the state they belong to
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cs_r  <= 1'b0;
            oe_r  <= 1'b0;
            web_r <= {STRB_W{1'b1}};
            a_r   <= {ADDR_W{1'b0}};
            di_r  <= {DATA_W{1'b0}};
        end else begin
            cs_r <= (state_s == ST_ACCESS);
            oe_r <= (state_s == ST_READ);
            if (grant_s && win_we_s) begin
                web_r <= ~win_wstrb_s;
                di_r  <= win_wdata_s;
            end else begin
                web_r <= {STRB_W{1'b1}};
            end
            if (grant_s) begin
                a_r <= win_addr_s;
            end
        end
    end

    // Response channel: valid held through backpressure, read data captured at the end of READ
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rsp_valid_r <= 2'b00;
            rdata_r     <= {DATA_W{1'b0}};
        end else begin
            if (state_s == ST_RESP) begin
                rsp_valid_r <= {id_r, ~id_r};
            end else begin
                rsp_valid_r <= 2'b00;
            end
            case (state_r)
                ST_READ: rdata_r <= DO;
                ST_RESP: begin
                    if (rsp_done_s) begin
                        rdata_r <= {DATA_W{1'b0}};
                    end else begin
                        rdata_r <= rdata_r;
                    end
                end
                default: rdata_r <= {DATA_W{1'b0}};
            endcase
        end
    end

    assign CS        = cs_r;
    assign OE        = oe_r;
    assign WEB       = web_r;
    assign A         = a_r;
    assign DI        = di_r;
    assign RSP_VALID = rsp_valid_r;
    assign RDATA     = rdata_r;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural byte-writable SRAM model.
module tb_sram_port_arbiter;

    logic        ACLK;
    logic        ARESET;
    logic [1:0]  REQ;
    logic [1:0]  WE;
    logic [27:0] ADDR;
    logic [7:0]  WSTRB;
    logic [63:0] WDATA;
    logic [1:0]  GNT;
    logic [1:0]  RSP_VALID;
    logic [1:0]  RSP_READY;
    logic [31:0] RDATA;
    logic        CS;
    logic        OE;
    logic [3:0]  WEB;
    logic [13:0] A;
    logic [31:0] DI;
    logic [31:0] DO;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [0:1023];
    logic        prev_cs;
    logic        prev_rd;

    sram_port_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .REQ(REQ), .WE(WE), .ADDR(ADDR),
        .WSTRB(WSTRB), .WDATA(WDATA), .GNT(GNT), .RSP_VALID(RSP_VALID),
        .RSP_READY(RSP_READY), .RDATA(RDATA), .CS(CS), .OE(OE), .WEB(WEB),
        .A(A), .DI(DI), .DO(DO)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Behavioural SRAM: byte writes on CS with WEB low, registered read data
    always @(posedge ACLK) begin
        if (CS === 1'b1) begin
            for (int b = 0; b < 4; b++) begin
                if (WEB[b] === 1'b0) mem[A[9:0]][b*8 +: 8] <= DI[b*8 +: 8];
            end
            DO <= mem[A[9:0]];
        end
    end

    // SRAM pin protocol monitor
    initial begin
        prev_cs = 1'b0;
        prev_rd = 1'b0;
        forever begin
            @(negedge ACLK);
            if (ARESET === 1'b0) begin
                checks++;
                if (CS === 1'b1 && prev_cs === 1'b1) begin
                    errors++;
                    $display("FAIL proto_cs_double: CS=%b prev CS=%b, required not both 1", CS, prev_cs);
                end
                checks++;
                if (OE === 1'b1 && prev_rd !== 1'b1) begin
                    errors++;
                    $display("FAIL proto_oe: OE=%b without preceding read access, required 0", OE);
                end
                checks++;
                if (WEB !== 4'hF && CS !== 1'b1) begin
                    errors++;
                    $display("FAIL proto_web: WEB=%h with CS=%b, required WEB=f", WEB, CS);
                end
            end
            prev_cs = (CS === 1'b1);
            prev_rd = (CS === 1'b1) && (WEB === 4'hF);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic pop_and_compare(input string name);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got response with empty scoreboard, expected an entry", name);
        end else begin
            e = sb_q.pop_front();
            if (RSP_VALID !== {e.id, ~e.id} || RDATA !== e.data) begin
                errors++;
                $display("FAIL %s: got valid=%b rdata=%h, expected valid=%b rdata=%h",
                         name, RSP_VALID, RDATA, {e.id, ~e.id}, e.data);
            end
        end
    endtask

    // One complete transaction; called and returns at a falling edge
    task automatic run_txn(input int id, input logic we, input logic [13:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input int delay, input logic hold_other);
        int          n;
        int          k;
        logic        idb;
        logic [31:0] rdata0;
        idb = (id == 1);
        WE[id] = we;
        ADDR[id*14 +: 14] = addr;
        WSTRB[id*4 +: 4] = strb;
        WDATA[id*32 +: 32] = wdata;
        REQ[id] = 1'b1;
        n = 0;
        #2;
        while (GNT[id] !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            #2;
            n++;
        end
        checks++;
        if (GNT !== {idb, ~idb}) begin
            errors++;
            $display("FAIL gnt: got %b, expected %b", GNT, {idb, ~idb});
            REQ[id] = 1'b0;
            return;
        end
        sb_q.push_back(exp_t'{idb, exp_rdata});
        @(negedge ACLK);
        REQ[id] = 1'b0;
        checks++;
        if (CS !== 1'b1 || A !== addr || WEB !== (we ? ~strb : 4'hF) || (we && DI !== wdata)) begin
            errors++;
            $display("FAIL access: got CS=%b A=%h WEB=%h DI=%h, expected CS=1 A=%h WEB=%h DI=%h",
                     CS, A, WEB, DI, addr, (we ? ~strb : 4'hF), wdata);
        end
        k = 1;
        while (RSP_VALID[id] !== 1'b1 && k < 12) begin
            @(negedge ACLK);
            k++;
            if (k == 2 && !we) begin
                checks++;
                if (OE !== 1'b1 || CS !== 1'b0) begin
                    errors++;
                    $display("FAIL read_oe: got OE=%b CS=%b, expected OE=1 CS=0", OE, CS);
                end
            end
        end
        checks++;
        if (k != (we ? 2 : 3)) begin
            errors++;
            $display("FAIL latency: got RSP_VALID at T+%0d, expected T+%0d", k, (we ? 2 : 3));
        end
        if (hold_other) REQ[1-id] = 1'b1;
        rdata0 = RDATA;
        for (int d = 0; d < delay; d++) begin
            @(negedge ACLK);
            checks++;
            if (RSP_VALID[id] !== 1'b1 || RDATA !== rdata0 || GNT !== 2'b00) begin
                errors++;
                $display("FAIL hold: got valid=%b rdata=%h gnt=%b, expected valid=1 rdata=%h gnt=00",
                         RSP_VALID[id], RDATA, GNT, rdata0);
            end
        end
        RSP_READY[id] = 1'b1;
        pop_and_compare("rsp");
        @(negedge ACLK);
        RSP_READY[id] = 1'b0;
        checks++;
        if (RSP_VALID[id] !== 1'b0) begin
            errors++;
            $display("FAIL rsp_drop: got valid=%b, expected 0", RSP_VALID[id]);
        end
    endtask

    task automatic test_reset();
        @(negedge ACLK);
        checks++;
        if ({GNT, RSP_VALID, RDATA, CS, OE, WEB, A, DI} !== {2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 4'hF, 14'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset: got GNT=%b VALID=%b RDATA=%h CS=%b OE=%b WEB=%h A=%h DI=%h, expected 00 00 0 0 0 f 0 0",
                     GNT, RSP_VALID, RDATA, CS, OE, WEB, A, DI);
        end
        ARESET = 1'b0;
    endtask

    task automatic test_write_read();
        run_txn(0, 1'b1, 14'h0010, 4'hF, 32'hDEADBEEF, 32'h0, 0, 1'b0);
        run_txn(0, 1'b0, 14'h0010, 4'hF, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    endtask

    task automatic test_byte_strobe();
        run_txn(0, 1'b1, 14'h0020, 4'hF, 32'h11223344, 32'h0, 0, 1'b0);
        run_txn(1, 1'b1, 14'h0020, 4'b0101, 32'hAABBCCDD, 32'h0, 0, 1'b0);
        run_txn(1, 1'b0, 14'h0020, 4'hF, 32'h0, 32'h11BB33DD, 0, 1'b0);
    endtask

    task automatic test_zero_strobe();
        run_txn(1, 1'b1, 14'h0010, 4'h0, 32'h12345678, 32'h0, 0, 1'b0);
        run_txn(0, 1'b0, 14'h0010, 4'hF, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        WE[1] = 1'b0;
        ADDR[27:14] = 14'h0020;
        run_txn(0, 1'b0, 14'h0010, 4'hF, 32'h0, 32'hDEADBEEF, 5, 1'b1);
        checks++;
        if (GNT !== 2'b10) begin
            errors++;
            $display("FAIL gnt_after_bp: got %b, expected 10", GNT);
        end
        run_txn(1, 1'b0, 14'h0020, 4'hF, 32'h0, 32'h11BB33DD, 0, 1'b0);
    endtask

    task automatic test_tie();
        int n;
        int exp_w;
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        WE = 2'b00;
        ADDR = {14'h0020, 14'h0010};
        RSP_READY = 2'b11;
        REQ = 2'b11;
        #2;
        for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            exp_w = i % 2;
`else
            exp_w = 0;
`endif
            n = 0;
            while (GNT === 2'b00 && n < 20) begin
                @(negedge ACLK);
                n++;
            end
            checks++;
            if (GNT !== ((exp_w == 1) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL tie_order[%0d]: got %b, expected %b", i, GNT, ((exp_w == 1) ? 2'b10 : 2'b01));
            end
            sb_q.push_back(exp_t'{(exp_w == 1), ((exp_w == 1) ? 32'h11BB33DD : 32'hDEADBEEF)});
            @(negedge ACLK);
            n = 0;
            while (RSP_VALID === 2'b00 && n < 20) begin
                @(negedge ACLK);
                n++;
            end
            pop_and_compare("tie_rsp");
            @(negedge ACLK);
        end
        REQ = 2'b00;
        RSP_READY = 2'b00;
    endtask

    task automatic test_reset_mid_read();
        int n;
        @(negedge ACLK);
        ADDR[13:0] = 14'h0010;
        WE = 2'b00;
        REQ = 2'b01;
        #2;
        checks++;
        if (GNT !== 2'b01) begin
            errors++;
            $display("FAIL mid_gnt: got %b, expected 01", GNT);
        end
        @(negedge ACLK);
        REQ = 2'b00;
        @(negedge ACLK);
        checks++;
        if (OE !== 1'b1) begin
            errors++;
            $display("FAIL mid_read_state: got OE=%b, expected 1", OE);
        end
        ARESET = 1'b1;
        #1;
        checks++;
        if ({CS, OE, WEB, RSP_VALID} !== {1'b0, 1'b0, 4'hF, 2'b00}) begin
            errors++;
            $display("FAIL rst_async: got CS=%b OE=%b WEB=%h VALID=%b, expected 0 0 f 00", CS, OE, WEB, RSP_VALID);
        end
        @(posedge ACLK);
        #1;
        checks++;
        if ({CS, OE, WEB, RSP_VALID} !== {1'b0, 1'b0, 4'hF, 2'b00}) begin
            errors++;
            $display("FAIL rst_edge: got CS=%b OE=%b WEB=%h VALID=%b, expected 0 0 f 00", CS, OE, WEB, RSP_VALID);
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        ADDR = {14'h0020, 14'h0010};
        REQ = 2'b11;
        #2;
        checks++;
        if (GNT !== 2'b01) begin
            errors++;
            $display("FAIL post_rst_gnt: got %b, expected 01", GNT);
        end
        sb_q.push_back(exp_t'{1'b0, 32'hDEADBEEF});
        @(negedge ACLK);
        REQ = 2'b00;
        n = 0;
        while (RSP_VALID !== 2'b01 && n < 10) begin
            @(negedge ACLK);
            n++;
        end
        RSP_READY = 2'b01;
        pop_and_compare("post_rst_rsp");
        @(negedge ACLK);
        RSP_READY = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        DO = 32'h0;
        ARESET = 1'b1;
        REQ = 2'b00;
        WE = 2'b00;
        ADDR = 28'h0;
        WSTRB = 8'h00;
        WDATA = 64'h0;
        RSP_READY = 2'b00;
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_zero_strobe();
        test_backpressure();
        test_tie();
        test_reset_mid_read();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_empty: got %0d pending, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
